// File: rtl/async_ring_bridge.sv
// Launch/monitor bridge between the clocked core and the async controller ring.
// Optional watchdog built when ASYNC_BRIDGE_WDOG_EN is defined.
module async_ring_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             halt_i,
    output logic             req_start_o,
    input  logic             ack_start_i,
    input  logic             retire_i,
    output logic             busy_o,
    output logic             retire_pulse_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic             timeout_o
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        TIMEOUT < 2 || TIMEOUT > (1 << 20)) begin : g_bad_param
        $error("async_ring_bridge: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_L_REQ,
        S_L_REL,
        S_RUN,
        S_TIMEOUT
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [SYNC_STAGES-1:0] ret_sync;
    logic                   ret_prev;
    logic                   ack_s;
    logic                   rise;
    logic                   launch;
    logic                   counting;
    logic                   expire;
    logic                   halt_seen;
    logic                   req_q;
    logic                   pulse_q;
    logic [CNT_W-1:0]       cnt_q;

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign rise     = ret_sync[SYNC_STAGES-1] ^ ret_prev;
    assign launch   = start_i &&
                      (state_q == S_IDLE || state_q == S_TIMEOUT);
    assign counting = state_q inside {S_L_REQ, S_L_REL, S_RUN};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync <= '0;
            ret_sync <= '0;
            ret_prev <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_start_i};
            ret_sync <= {ret_sync[SYNC_STAGES-2:0], retire_i};
            ret_prev <= ret_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_TIMEOUT: begin
                if (start_i) state_d = S_L_REQ;
            end
            S_L_REQ: begin
                if (ack_s) state_d = S_L_REL;
            end
            S_L_REL: begin
                if (!ack_s) begin
                    state_d = (halt_seen || halt_i) ? S_IDLE : S_RUN;
                end
            end
            S_RUN: begin
                if (halt_i)      state_d = S_IDLE;
                else if (expire) state_d = S_TIMEOUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A halt during launch is only honoured once the handshake has closed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_seen <= 1'b0;
        end else if (launch) begin
            halt_seen <= 1'b0;
        end else if (halt_i &&
                     (state_q == S_L_REQ || state_q == S_L_REL)) begin
            halt_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= 1'b0;
        end else begin
            req_q <= (state_d == S_L_REQ);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= counting && rise;
            if (launch) begin
                cnt_q <= '0;
            end else if (counting && rise) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef ASYNC_BRIDGE_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    // A retire edge arriving on the expiry cycle keeps the ring alive.
    assign expire = (state_q == S_RUN) && !halt_i && !rise &&
                    (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != S_RUN || rise) begin
                wd_q <= '0;
            end else if (!expire) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (launch) begin
                timeout_q <= 1'b0;
            end else if (expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign req_start_o    = req_q;
    assign busy_o         = state_q inside {S_L_REQ, S_L_REL, S_RUN};
    assign retire_pulse_o = pulse_q;
    assign retire_cnt_o   = cnt_q;

endmodule

// File: tb/tb_async_ring_bridge.sv
// Self-checking bench for async_ring_bridge: launch handshake, retire
// counting with wrap, halt handling, watchdog and asynchronous reset.
module tb_async_ring_bridge;

    localparam int S     = 2;
    localparam int CW    = 4;
    localparam int TMO   = 16;
    localparam int MOD   = 1 << CW;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          halt_i;
    logic          req_start_o;
    logic          ack_start_i;
    logic          retire_i;
    logic          busy_o;
    logic          retire_pulse_o;
    logic [CW-1:0] retire_cnt_o;
    logic          timeout_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_cnt = 0;
    int ack_rise_cyc = -1;
    int ack_fall_cyc = -1;

    async_ring_bridge #(
        .SYNC_STAGES(S),
        .CNT_W      (CW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start_i),
        .halt_i        (halt_i),
        .req_start_o   (req_start_o),
        .ack_start_i   (ack_start_i),
        .retire_i      (retire_i),
        .busy_o        (busy_o),
        .retire_pulse_o(retire_pulse_o),
        .retire_cnt_o  (retire_cnt_o),
        .timeout_o     (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Fetch controller model: ack follows req three cycles later.
    initial begin
        logic [2:0] hist;
        logic       nxt;
        hist = '0;
        ack_start_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                hist = '0;
                ack_start_i = 1'b0;
            end else begin
                nxt = hist[2];
                if (nxt && !ack_start_i) ack_rise_cyc = cyc;
                if (!nxt && ack_start_i) ack_fall_cyc = cyc;
                ack_start_i = nxt;
                hist = {hist[1:0], req_start_o};
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_launch(input bit halt_mid, output int entry);
        int n;
        entry = -1;
        ack_rise_cyc = -1;
        ack_fall_cyc = -1;
        exp_cnt = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        total++;
        if (req_start_o !== 1'b1) begin
            bad++;
            $display("FAIL req_rise: got %b want 1", req_start_o);
        end
        total++;
        if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL launch_flags: busy=%b timeout=%b want 1/0",
                     busy_o, timeout_o);
        end
        total++;
        if (retire_cnt_o !== CW'(exp_cnt)) begin
            bad++;
            $display("FAIL launch_cnt: got %0d want %0d",
                     retire_cnt_o, exp_cnt);
        end
        if (halt_mid) begin
            halt_i = 1'b1;
            tick();
            halt_i = 1'b0;
        end
        n = 0;
        while (req_start_o && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (req_start_o !== 1'b0 || ack_rise_cyc < 0) begin
            bad++;
            $display("FAIL req_fall: req=%b ack_rise=%0d want 0 and ack",
                     req_start_o, ack_rise_cyc);
            return;
        end
        total++;
        if (cyc - ack_rise_cyc !== S + 1) begin
            bad++;
            $display("FAIL req_fall_lat: got %0d want %0d",
                     cyc - ack_rise_cyc, S + 1);
        end
        n = 0;
        while (ack_fall_cyc < 0 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (ack_fall_cyc < 0) begin
            bad++;
            $display("FAIL ack_fall: got none want fall");
            return;
        end
        while (cyc < ack_fall_cyc + S) tick();
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL busy_rel: got %b want 1", busy_o);
        end
        tick();
        total++;
        if (busy_o !== !halt_mid) begin
            bad++;
            $display("FAIL busy_after: got %b want %b", busy_o, !halt_mid);
        end
        entry = cyc;
    endtask

    task automatic toggle_series(input int n, input bit rnd,
                                 input bit counting);
        int sp;
        int due;
        for (int k = 0; k < n; k++) begin
            sp = rnd ? int'($urandom_range(S + 1, 8)) : 10;
            retire_i = ~retire_i;
            due = cyc + S + 1;
            for (int j = 0; j < sp; j++) begin
                tick();
                if (counting && cyc == due) exp_cnt = (exp_cnt + 1) % MOD;
                total++;
                if (retire_pulse_o !== (counting && cyc == due)) begin
                    bad++;
                    $display("FAIL pulse: cyc=%0d got %b want %b", cyc,
                             retire_pulse_o, counting && cyc == due);
                end
                total++;
                if (retire_cnt_o !== CW'(exp_cnt)) begin
                    bad++;
                    $display("FAIL count: cyc=%0d got %0d want %0d", cyc,
                             retire_cnt_o, exp_cnt);
                end
            end
        end
    endtask

    task automatic do_halt;
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL halt_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({req_start_o, busy_o, retire_pulse_o, timeout_o,
             retire_cnt_o} !== '0) begin
            bad++;
            $display("FAIL %s: req=%b busy=%b pulse=%b tmo=%b cnt=%0d want 0",
                     name, req_start_o, busy_o, retire_pulse_o, timeout_o,
                     retire_cnt_o);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_i = 1'b0;
        halt_i = 1'b0;
        retire_i = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        tick();
        check_all_zero("reset_release");
    endtask

    task automatic test_launch;
        int e;
        do_launch(1'b0, e);
        total++;
        if (retire_cnt_o !== 0 || timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL run_state: cnt=%0d tmo=%b want 0/0",
                     retire_cnt_o, timeout_o);
        end
    endtask

    task automatic test_retire;
        toggle_series(5, 1'b0, 1'b1);
        total++;
        if (retire_cnt_o !== CW'(5)) begin
            bad++;
            $display("FAIL retire_five: got %0d want 5", retire_cnt_o);
        end
    endtask

    task automatic test_halt_run;
        do_halt();
        repeat (4) tick();
        total++;
        if (retire_cnt_o !== CW'(exp_cnt) || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: cnt=%0d busy=%b want %0d/0",
                     retire_cnt_o, busy_o, exp_cnt);
        end
    endtask

    task automatic test_wrap;
        int e;
        do_launch(1'b0, e);
        toggle_series(17, 1'b1, 1'b1);
        total++;
        if (retire_cnt_o !== CW'(1)) begin
            bad++;
            $display("FAIL wrap: got %0d want 1", retire_cnt_o);
        end
        do_halt();
    endtask

    task automatic test_watchdog;
        int e;
        int n;
        do_launch(1'b0, e);
`ifdef ASYNC_BRIDGE_WDOG_EN
        n = 0;
        while (!timeout_o && n < TMO + 10) begin
            tick();
            n++;
        end
        total++;
        if (timeout_o !== 1'b1 || cyc - e !== TMO) begin
            bad++;
            $display("FAIL wdog_time: tmo=%b after %0d want 1 after %0d",
                     timeout_o, cyc - e, TMO);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL wdog_busy: got %b want 0", busy_o);
        end
        do_launch(1'b0, e);
`else
        n = 0;
        repeat (TMO + 24) begin
            tick();
            if (timeout_o !== 1'b0 || busy_o !== 1'b1) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL no_wdog: got %0d bad cycles want 0", n);
        end
`endif
        do_halt();
    endtask

    task automatic test_halt_launch;
        int e;
        int n;
        do_launch(1'b1, e);
        toggle_series(2, 1'b0, 1'b0);
        total++;
        if (retire_cnt_o !== CW'(0)) begin
            bad++;
            $display("FAIL idle_toggle: got %0d want 0", retire_cnt_o);
        end
        do_launch(1'b0, e);
        n = 0;
        repeat (10) begin
            tick();
            if (retire_pulse_o !== 1'b0 || retire_cnt_o !== CW'(0)) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL stale_edge: got %0d bad cycles want 0", n);
        end
        do_halt();
    endtask

    task automatic test_reset_mid;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        total++;
        if (req_start_o !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_req: got %b want 1", req_start_o);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (req_start_o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_req: got %b want 0", req_start_o);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        repeat (2) tick();
        check_all_zero("reset_mid_release");
    endtask

    initial begin
        test_reset();
        test_launch();
        test_retire();
        test_halt_run();
        test_wrap();
        test_watchdog();
        test_halt_launch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
